// File: rtl/mips_pipeline.sv
// Five-stage pipelined MIPS subset core (IF/ID/EX/MEM/WB) with internal
// 64-word instruction and data memories, forwarding, load-use stall and halt.

module mips_mem (
    input  logic        clk,
    input  logic        we,
    input  logic [5:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] mem [0:63];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

module mips_pipeline (
    input  logic clk,
    input  logic pcclr,
    output logic fin
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc4;
    } ifid_t;

    typedef struct packed {
        logic [31:0] rs_val, rt_val, imm, pc4;
        logic [4:0]  rs, rt, dst;
        alu_op_e     alu_op;
        logic        alu_imm, reg_write, mem_read, mem_write, beq, halt;
    } idex_t;

    typedef struct packed {
        logic [31:0] alu, store;
        logic [4:0]  dst;
        logic        reg_write, mem_read, mem_write, halt;
    } exmem_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  dst;
        logic        reg_write, halt;
    } memwb_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    logic [31:0] pc_q, pc_d, pc4;
    logic [31:0] pcdata_out, insmemins;
    ifid_t       ifid_q, ifid_d;
    idex_t       idex_q, idex_d, id_dec;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;
    logic        fin_q, fin_d;
    logic [31:0] rf_q [0:31];

    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_val, id_rt_val, id_jtarget;
    logic        id_use_rs, id_use_rt, id_jump, load_use, wb_we;

    logic [31:0] fwd_a, fwd_b, op_b, alu_res, ex_target;
    logic        ex_taken, exmem_fwd, memwb_fwd;

    logic [31:0] dmem_rdata;
    logic        dmem_we;

    // IF
    assign pcdata_out = pc_q;
    assign pc4        = pc_q + 32'd4;

    mips_mem insmem (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pc_q[7:2]),
        .wdata (32'd0),
        .rdata (insmemins)
    );

    // ID
    assign id_op      = ifid_q.ins[31:26];
    assign id_rs      = ifid_q.ins[25:21];
    assign id_rt      = ifid_q.ins[20:16];
    assign id_rd      = ifid_q.ins[15:11];
    assign id_funct   = ifid_q.ins[5:0];
    assign id_jtarget = {ifid_q.pc4[31:28], ifid_q.ins[25:0], 2'b00};
    assign wb_we      = memwb_q.reg_write && (memwb_q.dst != 5'd0) && !fin_q;

    // Register file read with same-cycle bypass of the WB write
    always_comb begin
        id_rs_val = rf_q[id_rs];
        id_rt_val = rf_q[id_rt];
        if (wb_we && (memwb_q.dst == id_rs)) id_rs_val = memwb_q.wdata;
        if (wb_we && (memwb_q.dst == id_rt)) id_rt_val = memwb_q.wdata;
        if (id_rs == 5'd0) id_rs_val = '0;
        if (id_rt == 5'd0) id_rt_val = '0;
    end

    always_comb begin
        id_dec        = '0;
        id_dec.rs     = id_rs;
        id_dec.rt     = id_rt;
        id_dec.pc4    = ifid_q.pc4;
        id_dec.imm    = {{16{ifid_q.ins[15]}}, ifid_q.ins[15:0]};
        id_dec.rs_val = id_rs_val;
        id_dec.rt_val = id_rt_val;
        id_dec.alu_op = ALU_ADD;
        id_use_rs     = 1'b0;
        id_use_rt     = 1'b0;
        id_jump       = 1'b0;
        case (id_op)
            OP_RTYPE: begin
                id_dec.dst       = id_rd;
                id_dec.reg_write = 1'b1;
                id_use_rs        = 1'b1;
                id_use_rt        = 1'b1;
                case (id_funct)
                    6'b100000: id_dec.alu_op = ALU_ADD;
                    6'b100010: id_dec.alu_op = ALU_SUB;
                    6'b100100: id_dec.alu_op = ALU_AND;
                    6'b100101: id_dec.alu_op = ALU_OR;
                    6'b101010: id_dec.alu_op = ALU_SLT;
                    default: begin
                        id_dec.reg_write = 1'b0;
                        id_use_rs        = 1'b0;
                        id_use_rt        = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                id_dec.dst       = id_rt;
                id_dec.alu_imm   = 1'b1;
                id_dec.reg_write = 1'b1;
                id_use_rs        = 1'b1;
            end
            OP_LW: begin
                id_dec.dst       = id_rt;
                id_dec.alu_imm   = 1'b1;
                id_dec.reg_write = 1'b1;
                id_dec.mem_read  = 1'b1;
                id_use_rs        = 1'b1;
            end
            OP_SW: begin
                id_dec.alu_imm   = 1'b1;
                id_dec.mem_write = 1'b1;
                id_use_rs        = 1'b1;
                id_use_rt        = 1'b1;
            end
            OP_BEQ: begin
                id_dec.beq = 1'b1;
                id_use_rs  = 1'b1;
                id_use_rt  = 1'b1;
            end
            OP_J:    id_jump     = 1'b1;
            OP_HALT: id_dec.halt = 1'b1;
            default: ;
        endcase
    end

    assign load_use = idex_q.mem_read && (idex_q.dst != 5'd0) &&
                      ((id_use_rs && (id_rs == idex_q.dst)) ||
                       (id_use_rt && (id_rt == idex_q.dst)));

    // EX: forwarding prefers the younger EX/MEM result over MEM/WB
    assign exmem_fwd = exmem_q.reg_write && (exmem_q.dst != 5'd0);
    assign memwb_fwd = memwb_q.reg_write && (memwb_q.dst != 5'd0);

    always_comb begin
        fwd_a = idex_q.rs_val;
        fwd_b = idex_q.rt_val;
        if (exmem_fwd && (exmem_q.dst == idex_q.rs))      fwd_a = exmem_q.alu;
        else if (memwb_fwd && (memwb_q.dst == idex_q.rs)) fwd_a = memwb_q.wdata;
        if (exmem_fwd && (exmem_q.dst == idex_q.rt))      fwd_b = exmem_q.alu;
        else if (memwb_fwd && (memwb_q.dst == idex_q.rt)) fwd_b = memwb_q.wdata;
    end

    assign op_b      = idex_q.alu_imm ? idex_q.imm : fwd_b;
    assign ex_taken  = idex_q.beq && (fwd_a == fwd_b);
    assign ex_target = idex_q.pc4 + {idex_q.imm[29:0], 2'b00};

    always_comb begin
        alu_res = '0;
        case (idex_q.alu_op)
            ALU_ADD: alu_res = fwd_a + op_b;
            ALU_SUB: alu_res = fwd_a - op_b;
            ALU_AND: alu_res = fwd_a & op_b;
            ALU_OR:  alu_res = fwd_a | op_b;
            ALU_SLT: alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
            default: alu_res = '0;
        endcase
    end

    // MEM: writes are blocked from the edge at which the halt retires onward
    assign dmem_we = exmem_q.mem_write && !(fin_q || memwb_q.halt);

    mips_mem datamem (
        .clk   (clk),
        .we    (dmem_we),
        .addr  (exmem_q.alu[7:2]),
        .wdata (exmem_q.store),
        .rdata (dmem_rdata)
    );

    always_comb begin
        pc_d       = pc4;
        ifid_d.ins = insmemins;
        ifid_d.pc4 = pc4;
        idex_d     = id_dec;

        exmem_d.alu       = alu_res;
        exmem_d.store     = fwd_b;
        exmem_d.dst       = idex_q.dst;
        exmem_d.reg_write = idex_q.reg_write;
        exmem_d.mem_read  = idex_q.mem_read;
        exmem_d.mem_write = idex_q.mem_write;
        exmem_d.halt      = idex_q.halt;

        memwb_d.wdata     = exmem_q.mem_read ? dmem_rdata : exmem_q.alu;
        memwb_d.dst       = exmem_q.dst;
        memwb_d.reg_write = exmem_q.reg_write;
        memwb_d.halt      = exmem_q.halt;

        fin_d = fin_q | memwb_q.halt;

        if (ex_taken) begin
            pc_d   = ex_target;
            ifid_d = '0;
            idex_d = '0;
        end else if (load_use) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
            idex_d = '0;
        end else if (id_jump) begin
            pc_d   = id_jtarget;
            ifid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge pcclr) begin
        if (pcclr) begin
            pc_q    <= '0;
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            fin_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            fin_q   <= fin_d;
        end
    end

    always_ff @(posedge clk or posedge pcclr) begin
        if (pcclr) begin
            for (int unsigned i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we) begin
            rf_q[memwb_q.dst] <= memwb_q.wdata;
        end
    end

    assign fin = fin_q;
endmodule

// File: tb/tb_mips_pipeline.sv
// Directed bench for mips_pipeline: loads small programs into the instruction
// memory, runs them to fin and checks data memory, cycle counts and reset.

module tb_mips_pipeline;
    logic clk   = 1'b0;
    logic pcclr = 1'b1;
    logic fin;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [31:0] prog [$];

    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_OR    = 6'b100101;

    mips_pipeline dut (
        .clk   (clk),
        .pcclr (pcclr),
        .fin   (fin)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'b000010, target};
    endfunction

    function automatic logic [31:0] enc_halt();
        return {6'b111111, 26'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Holds reset, wipes both memories and loads the current program
    task automatic load_prog();
        pcclr = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            dut.insmem.mem[i]  = '0;
            dut.datamem.mem[i] = '0;
        end
        for (int i = 0; i < prog.size(); i++) begin
            dut.insmem.mem[i] = prog[i];
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        pcclr = 1'b0;
    endtask

    // lat = edges between first fetch and fin; -1 if the budget expires
    task automatic run_to_fin(input int max_cycles, output int latency);
        int n;
        n = 0;
        latency = -1;
        while (n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
            if (fin === 1'b1) begin
                latency = n - 1;
                break;
            end
        end
    endtask

    initial begin
        // 1: straight-line ALU, plus reset state
        prog = '{enc_i(OP_ADDI, 0, 1, 16'd5), enc_i(OP_ADDI, 0, 2, 16'd7),
                 enc_r(F_ADD, 1, 2, 3), enc_i(OP_SW, 0, 3, 16'd4), enc_halt()};
        load_prog();
        #1;
        check("reset_pc", dut.pcdata_out, 32'd0);
        check("reset_fin", {31'd0, fin}, 32'd0);
        check("reset_ins", dut.insmemins, prog[0]);
        release_rst();
        run_to_fin(40, lat);
        check("alu_latency", lat, 32'd8);
        check("alu_mem1", dut.datamem.mem[1], 32'd12);

        // 2: back-to-back forwarding chain
        prog = '{enc_i(OP_ADDI, 0, 1, 16'd3), enc_r(F_SUB, 1, 1, 2),
                 enc_r(F_OR, 1, 2, 3), enc_i(OP_SW, 0, 3, 16'd16), enc_halt()};
        load_prog();
        release_rst();
        run_to_fin(40, lat);
        check("fwd_latency", lat, 32'd8);
        check("fwd_mem4", dut.datamem.mem[4], 32'd3);

        // 3: load-use costs exactly one stall
        prog = '{enc_i(OP_ADDI, 0, 1, 16'd9), enc_i(OP_SW, 0, 1, 16'd64),
                 enc_i(OP_LW, 0, 4, 16'd64), enc_r(F_ADD, 4, 4, 5),
                 enc_i(OP_SW, 0, 5, 16'd4), enc_halt()};
        load_prog();
        release_rst();
        run_to_fin(40, lat);
        check("lu_latency", lat, 32'd10);
        check("lu_mem16", dut.datamem.mem[16], 32'd9);
        check("lu_mem1", dut.datamem.mem[1], 32'd18);

        // 4: taken beq skips two stores, untaken beq falls through
        prog = '{enc_i(OP_ADDI, 0, 1, 16'd1), enc_i(OP_BEQ, 0, 0, 16'd2),
                 enc_i(OP_SW, 0, 1, 16'd4), enc_i(OP_SW, 0, 1, 16'd16),
                 enc_i(OP_BEQ, 1, 0, 16'd1), enc_i(OP_SW, 0, 1, 16'd64), enc_halt()};
        load_prog();
        release_rst();
        run_to_fin(40, lat);
        check("br_latency", lat, 32'd10);
        check("br_mem1", dut.datamem.mem[1], 32'd0);
        check("br_mem4", dut.datamem.mem[4], 32'd0);
        check("br_mem16", dut.datamem.mem[16], 32'd1);

        // 5: halts in the shadow of a taken beq are discarded
        prog = '{enc_i(OP_BEQ, 0, 0, 16'd2), enc_halt(), enc_halt(),
                 enc_i(OP_ADDI, 0, 1, 16'd5), enc_i(OP_SW, 0, 1, 16'd4), enc_halt()};
        load_prog();
        release_rst();
        run_to_fin(40, lat);
        check("shadow_latency", lat, 32'd9);
        check("shadow_mem1", dut.datamem.mem[1], 32'd5);

        // 6: j flushes one slot; stores after halt are suppressed
        prog = '{enc_i(OP_ADDI, 0, 1, 16'd7), enc_j(26'd3),
                 enc_i(OP_SW, 0, 1, 16'd4), enc_i(OP_SW, 0, 1, 16'd8), enc_halt(),
                 enc_i(OP_SW, 0, 1, 16'd12), enc_i(OP_ADDI, 0, 2, 16'd1),
                 enc_i(OP_SW, 0, 2, 16'd16)};
        load_prog();
        release_rst();
        run_to_fin(40, lat);
        check("j_latency", lat, 32'd8);
        repeat (10) @(posedge clk);
        #1;
        check("j_mem1", dut.datamem.mem[1], 32'd0);
        check("j_mem2", dut.datamem.mem[2], 32'd7);
        check("post_halt_mem3", dut.datamem.mem[3], 32'd0);
        check("post_halt_mem4", dut.datamem.mem[4], 32'd0);
        check("fin_sticky", {31'd0, fin}, 32'd1);

        // 7: asynchronous reset while fin is high
        @(negedge clk);
        #2;
        pcclr = 1'b1;
        #1;
        check("areset_pc", dut.pcdata_out, 32'd0);
        check("areset_fin", {31'd0, fin}, 32'd0);

        // 8: mid-program reset, then $1 must read as cleared
        prog = '{enc_i(OP_SW, 0, 1, 16'd4), enc_halt()};
        load_prog();
        release_rst();
        repeat (3) @(posedge clk);
        #2;
        pcclr = 1'b1;
        #1;
        check("midrun_pc", dut.pcdata_out, 32'd0);
        load_prog();
        dut.datamem.mem[1] = 32'hDEADBEEF;
        release_rst();
        run_to_fin(40, lat);
        check("rfclr_latency", lat, 32'd5);
        check("rfclr_mem1", dut.datamem.mem[1], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
